frame_config_sequencer: RTL



---
 rtl/frame_config_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/frame_config_sequencer.sv
// Word-stream configuration sequencer: finds the sync word, decodes frame headers
// and drives FrameData plus a registered one-hot FrameStrobe into the tile columns.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | hunting for SYNC_WORD, all other words discarded
// S_HEADER | next word is a frame header (col / first / count)
// S_DATA   | next word is frame data for (col, frame_idx)
// S_STROBE | single-cycle strobe of the frame latched in S_DATA
module frame_config_sequencer #(
    parameter int                DATA_W         = 32,
    parameter int                NUM_COLS       = 16,
    parameter int                FRAMES_PER_COL = 20,
    parameter logic [DATA_W-1:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
    input  logic                               CLK,
    input  logic                               resetn,
    input  logic [DATA_W-1:0]                  s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [DATA_W-1:0]                  FrameData,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                               busy,
    output logic                               cfg_error,
    output logic [15:0]                        frames_done
);

    localparam int NUM_STROBES = NUM_COLS * FRAMES_PER_COL;
    localparam int COL_W       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int FRM_W       = $clog2(FRAMES_PER_COL + 1);
    localparam int IDX_W       = (NUM_STROBES > 1) ? $clog2(NUM_STROBES) : 1;

    localparam logic [8:0]  COL_LIMIT = 9'(NUM_COLS);
    localparam logic [16:0] FRM_LIMIT = 17'(FRAMES_PER_COL);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_STROBE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [COL_W-1:0]       col_q;
    logic [FRM_W-1:0]       frame_idx;
    logic [15:0]            remaining;
    logic [NUM_STROBES-1:0] strobe_q;

    logic                   xfer;
    logic                   sync_hit;
    logic [7:0]             hdr_col;
    logic [7:0]             hdr_first;
    logic [15:0]            hdr_count;
    logic [16:0]            hdr_end;
    logic                   hdr_end_of_stream;
    logic                   hdr_in_range;
    logic [IDX_W-1:0]       strobe_idx;
    logic [NUM_STROBES-1:0] strobe_onehot;

    assign xfer     = s_valid && s_ready;
    assign sync_hit = (s_data == SYNC_WORD);

    // Header fields; the range check is done in 17 bits so first+count cannot wrap.
    always_comb begin
        hdr_col           = s_data[31:24];
        hdr_first         = s_data[23:16];
        hdr_count         = s_data[15:0];
        hdr_end           = {9'd0, hdr_first} + {1'b0, hdr_count};
        hdr_end_of_stream = (hdr_count == 16'd0);
        hdr_in_range      = ({1'b0, hdr_col} < COL_LIMIT) && (hdr_end <= FRM_LIMIT);
    end

    always_comb begin
        strobe_idx    = IDX_W'(col_q) * IDX_W'(FRAMES_PER_COL) + IDX_W'(frame_idx);
        strobe_onehot = NUM_STROBES'(1) << strobe_idx;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (xfer && sync_hit) begin
                    state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    if (!hdr_end_of_stream && hdr_in_range) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    state_nxt = S_STROBE;
                end
            end
            S_STROBE: begin
                if (remaining == 16'd1) begin
                    state_nxt = S_HEADER;
                end else begin
                    state_nxt = S_DATA;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; gating by resetn keeps a strobe from escaping while reset is applied.
    always_comb begin
        s_ready     = resetn && (state != S_STROBE);
        busy        = (state != S_IDLE);
        FrameStrobe = strobe_q & {NUM_STROBES{resetn}};
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            col_q       <= '0;
            frame_idx   <= '0;
            remaining   <= '0;
            FrameData   <= '0;
            strobe_q    <= '0;
            cfg_error   <= 1'b0;
            frames_done <= '0;
        end else begin
            strobe_q <= '0;
            case (state)
                S_IDLE: begin
                    if (xfer && sync_hit) begin
                        cfg_error   <= 1'b0;
                        frames_done <= '0;
                    end
                end
                S_HEADER: begin
                    if (xfer && !hdr_end_of_stream) begin
                        if (hdr_in_range) begin
                            col_q     <= COL_W'(hdr_col);
                            frame_idx <= FRM_W'(hdr_first);
                            remaining <= hdr_count;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        FrameData <= s_data;
                        strobe_q  <= strobe_onehot;
                    end
                end
                S_STROBE: begin
                    if (frames_done != 16'hFFFF) begin
                        frames_done <= frames_done + 16'd1;
                    end
                    frame_idx <= frame_idx + FRM_W'(1);
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
